// File: rtl/tt_um_mux_arbiter.sv
// rtl/tt_um_mux_arbiter.sv - four-requester round-robin arbiter sharing a 1-bit mux path
module tt_um_mux_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [1:0] state;
  logic [3:0] gnt;
  logic [1:0] gidx;
  logic [1:0] ptr;
  logic [3:0] cnt;

  logic [3:0] req;
  logic [3:0] data;
  logic       lock;
  logic       any_req;
  logic       others_req;
  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] scan_idx;
  logic       dout;
  logic       busy;
  logic       unused;

  assign req        = ui_in[3:0];
  assign data       = ui_in[7:4];
  assign lock       = uio_in[0];
  assign any_req    = |req;
  assign others_req = |(req & ~gnt);
  assign unused     = &{1'b0, uio_in[7:1]};

  // First asserted request searching upward from ptr, wrapping mod 4.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    scan_idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + 2'(k);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      gnt   <= 4'b0000;
      gidx  <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= 4'd0;
    end else if (ena) begin
      case (state)
        S_IDLE, S_GAP: begin
          if (any_req) begin
            state <= S_GRANT;
            gnt   <= 4'b0001 << pick_idx;
            gidx  <= pick_idx;
            ptr   <= pick_idx + 2'd1;
            cnt   <= 4'd0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (cnt != HOLD_LAST) cnt <= cnt + 4'd1;
          // A dropped request wins over preemption; both land in GAP anyway.
          if (!req[gidx] || (cnt == HOLD_LAST && !lock && others_req)) begin
            state <= S_GAP;
            gnt   <= 4'b0000;
          end
        end
        default: begin
          state <= S_IDLE;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

  assign dout = (gnt != 4'b0000) ? data[gidx] : 1'b0;
  assign busy = (state != S_IDLE);

  assign uo_out  = {gidx, busy, dout, gnt};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_mux_arbiter.sv
// tb/tb_tt_um_mux_arbiter.sv - randomized check of the arbiter against a grant-history model
module tb_tt_um_mux_arbiter;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  tt_um_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: who owns the grant (-1 none), how long they have held it,
  // whether we are in the mandatory dead cycle, and the rotation pointer.
  int owner = -1;
  int last = 0;
  int ptr = 0;
  int held = 0;
  bit in_gap = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [7:0] o;
    o = 8'h00;
    if (owner >= 0) begin
      o[owner] = 1'b1;
      o[4] = ui_in[4 + owner];
    end
    o[5] = (owner >= 0) || in_gap;
    o[7:6] = 2'(last);
    return o;
  endfunction

  task automatic model_reset();
    owner = -1; last = 0; ptr = 0; held = 0; in_gap = 1'b0;
  endtask

  task automatic take(input logic [3:0] req);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (!found && req[i]) begin
        found = 1'b1;
        owner = i; last = i; ptr = (i + 1) % 4; held = 1;
      end
    end
  endtask

  task automatic model_step();
    logic [3:0] req;
    logic [3:0] mine;
    req = ui_in[3:0];
    if (owner >= 0) begin
      mine = 4'b0001 << owner;
      if (!req[owner]) begin
        owner = -1; in_gap = 1'b1;
      end else if (held >= MAX_HOLD && !uio_in[0] && (req & ~mine) != 4'b0000) begin
        owner = -1; in_gap = 1'b1;
      end else begin
        held++;
      end
    end else begin
      in_gap = 1'b0;
      if (req != 4'b0000) take(req);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (ena) model_step();
    @(negedge clk);
    check(tag, uo_out, model_out());
  endtask

  initial begin
    // Reset held with all requests up: outputs must stay quiet.
    ui_in = 8'h0F;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_out", uo_out, 8'h00);
    check("uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    cycle("rst_first");
    check("first_grant", uo_out, 8'h21);

    // Constant competition between 0 and 1, no lock: alternating MAX_HOLD windows.
    ui_in = 8'h03;
    repeat (40) cycle("preempt");

    // Lock keeps the owner; dropping its request still releases.
    uio_in = 8'h01;
    repeat (25) cycle("lock");
    ui_in = {4'h0, 4'h0 | (ui_in[3:0] & ~(4'b0001 << ((owner < 0) ? 0 : owner)))};
    repeat (4) cycle("lock_drop");
    uio_in = 8'h00;

    // Randomized traffic: sticky requests, random data, lock and enable.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] r;
      r = ui_in[3:0];
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      ui_in = {4'($urandom_range(0, 15)), r};
      if ($urandom_range(0, 7) == 0) uio_in = {7'($urandom_range(0, 127)), ~uio_in[0]};
      ena = ($urandom_range(0, 9) != 0);
      #1;
      check("comb", uo_out, model_out());
      if (n == 700 || n == 1200) begin
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        cycle("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
